// File: rtl/dev_port_fifo_pkg.sv
// rtl/dev_port_fifo_pkg.sv - shared packet layout and error-flag indices for dev_port_fifo
package dev_port_fifo_pkg;

    localparam int ID_W      = 8;
    localparam int PAYLOAD_W = 8;

    localparam int ERR_TX_OVF   = 0;
    localparam int ERR_RX_OVF   = 1;
    localparam int ERR_MISROUTE = 2;

    typedef struct packed {
        logic [ID_W-1:0]      dest;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with extra-MSB pointers
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A read on a full FIFO frees the slot being written in the same edge.
    assign rd_en = rd && !empty;
    assign wr_en = wr && (!full || rd_en);

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dev_port_fifo.sv
// rtl/dev_port_fifo.sv - device port with TX/RX FIFOs and address filter; DEV_PORT_FIFO_STATS_EN adds drop counters
module dev_port_fifo
    import dev_port_fifo_pkg::*;
#(
    parameter int         PCKG_SZ   = 16,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] DEV_ID    = 8'd0,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [PCKG_SZ-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    input  logic               pop,
    output logic [PCKG_SZ-1:0] D_pop,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] D_push,
    input  logic               rx_rd,
    output logic [PCKG_SZ-1:0] rx_data,
    output logic               rx_empty,
    output logic [2:0]         err_pulse
`ifdef DEV_PORT_FIFO_STATS_EN
    ,
    output logic [15:0]        tx_drop_cnt,
    output logic [15:0]        rx_drop_cnt,
    output logic [15:0]        misroute_cnt
`endif
);

    logic            tx_empty;
    logic            rx_full;
    logic [ID_W-1:0] push_dest;
    logic            addr_ok;
    logic            rx_wr;
    logic [2:0]      err_next;

    assign push_dest = D_push[PCKG_SZ-1 -: ID_W];
    assign addr_ok   = (push_dest == DEV_ID) || (push_dest == BROADCAST);
    assign rx_wr     = push && addr_ok;
    assign pndng     = !tx_empty;

    always_comb begin
        err_next               = '0;
        err_next[ERR_TX_OVF]   = tx_wr && tx_full && !pop;
        err_next[ERR_RX_OVF]   = rx_wr && rx_full && !rx_rd;
        err_next[ERR_MISROUTE] = push && !addr_ok;
    end

    sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_pulse <= '0;
        else       err_pulse <= err_next;
    end

`ifdef DEV_PORT_FIFO_STATS_EN
    // Counters saturate at all-ones rather than wrapping back to a misleading small value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_drop_cnt  <= '0;
            rx_drop_cnt  <= '0;
            misroute_cnt <= '0;
        end else begin
            if (err_next[ERR_TX_OVF] && tx_drop_cnt != 16'hFFFF)
                tx_drop_cnt <= tx_drop_cnt + 16'd1;
            if (err_next[ERR_RX_OVF] && rx_drop_cnt != 16'hFFFF)
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
            if (err_next[ERR_MISROUTE] && misroute_cnt != 16'hFFFF)
                misroute_cnt <= misroute_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dev_port_fifo.sv
// tb/tb_dev_port_fifo.sv - randomized queue-model bench for dev_port_fifo (DEV_ID=3, DEPTH=8)
module tb_dev_port_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_wr, pop, push, rx_rd;
    logic [15:0] tx_data, D_push;
    logic        tx_full, pndng, rx_empty;
    logic [15:0] D_pop, rx_data;
    logic [2:0]  err_pulse;
`ifdef DEV_PORT_FIFO_STATS_EN
    logic [15:0] tx_drop_cnt, rx_drop_cnt, misroute_cnt;
    int          m_txd, m_rxd, m_mis;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic [2:0]  exp_err;

    always #5 clk = ~clk;

    dev_port_fifo #(.PCKG_SZ(16), .DEPTH(DEPTH), .DEV_ID(8'd3), .BROADCAST(8'hFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .tx_full   (tx_full),
        .pndng     (pndng),
        .pop       (pop),
        .D_pop     (D_pop),
        .push      (push),
        .D_push    (D_push),
        .rx_rd     (rx_rd),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .err_pulse (err_pulse)
`ifdef DEV_PORT_FIFO_STATS_EN
        ,
        .tx_drop_cnt  (tx_drop_cnt),
        .rx_drop_cnt  (rx_drop_cnt),
        .misroute_cnt (misroute_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        tx_wr = 0; pop = 0; push = 0; rx_rd = 0; tx_data = '0; D_push = '0;
    endtask

    task automatic check_outputs();
        check("pndng",    32'(pndng),    32'(txq.size() > 0));
        check("tx_full",  32'(tx_full),  32'(txq.size() == DEPTH));
        check("D_pop",    32'(D_pop),    32'(txq.size() > 0 ? txq[0] : 16'h0));
        check("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
        check("rx_data",  32'(rx_data),  32'(rxq.size() > 0 ? rxq[0] : 16'h0));
        check("err",      32'(err_pulse), 32'(exp_err));
`ifdef DEV_PORT_FIFO_STATS_EN
        check("tx_drop_cnt",  32'(tx_drop_cnt),  32'(m_txd));
        check("rx_drop_cnt",  32'(rx_drop_cnt),  32'(m_rxd));
        check("misroute_cnt", 32'(misroute_cnt), 32'(m_mis));
`endif
    endtask

    // Apply the currently driven inputs for one clock and compare against the queue model.
    task automatic cycle();
        bit tx_is_full, rx_is_full, pop_ok, rd_ok, dest_ok;
        tx_is_full = (txq.size() == DEPTH);
        rx_is_full = (rxq.size() == DEPTH);
        pop_ok     = pop && txq.size() > 0;
        rd_ok      = rx_rd && rxq.size() > 0;
        dest_ok    = (D_push[15:8] == 8'h03) || (D_push[15:8] == 8'hFF);
        exp_err    = {push && !dest_ok, push && dest_ok && rx_is_full && !rx_rd,
                      tx_wr && tx_is_full && !pop};
        if (pop_ok) void'(txq.pop_front());
        if (tx_wr && (!tx_is_full || pop_ok)) txq.push_back(tx_data);
        if (rd_ok) void'(rxq.pop_front());
        if (push && dest_ok && (!rx_is_full || rd_ok)) rxq.push_back(D_push);
`ifdef DEV_PORT_FIFO_STATS_EN
        if (exp_err[0] && m_txd < 65535) m_txd++;
        if (exp_err[1] && m_rxd < 65535) m_rxd++;
        if (exp_err[2] && m_mis < 65535) m_mis++;
`endif
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic clear_model();
        txq.delete();
        rxq.delete();
        exp_err = '0;
`ifdef DEV_PORT_FIFO_STATS_EN
        m_txd = 0; m_rxd = 0; m_mis = 0;
`endif
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        clear_model();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        check_outputs();
    endtask

    initial begin
        idle();
        reset = 0;
        exp_err = '0;
        #2;
        do_reset();

        // Single packet through TX, then pop back to empty.
        tx_wr = 1; tx_data = 16'h0312; cycle();
        idle(); check("d_pop_0312", 32'(D_pop), 32'h0312);
        pop = 1; cycle();
        idle(); cycle();

        // Overflow TX, then write-while-full with pop.
        for (int i = 0; i < DEPTH + 1; i++) begin
            tx_wr = 1; tx_data = 16'h1000 + 16'(i); cycle();
        end
        check("tx_ovf_pulse", 32'(err_pulse[0]), 32'h1);
        tx_wr = 1; pop = 1; tx_data = 16'h2000; cycle();
        check("tx_full_stays", 32'(tx_full), 32'h1);
        idle(); cycle();

        // Address filter: own ID, broadcast, foreign ID.
        push = 1; D_push = 16'h0355; cycle();
        D_push = 16'hFF01; cycle();
        D_push = 16'h0577; cycle();
        check("misroute_pulse", 32'(err_pulse[2]), 32'h1);
        idle();
        for (int i = 0; i < 2; i++) begin rx_rd = 1; cycle(); end
        rx_rd = 1; cycle();
        idle();

        // Fill RX, overflow, drain in order.
        for (int i = 0; i < DEPTH + 1; i++) begin
            push = 1; D_push = 16'h0300 + 16'(i); cycle();
        end
        check("rx_ovf_pulse", 32'(err_pulse[1]), 32'h1);
        idle();
        for (int i = 0; i < DEPTH + 1; i++) begin rx_rd = 1; cycle(); end
        idle();

        // Asynchronous reset in the middle of a pop with TX holding entries.
        do_reset();
        for (int i = 0; i < 4; i++) begin tx_wr = 1; tx_data = 16'hA000 + 16'(i); cycle(); end
        idle();
        pop = 1;
        #2 reset = 1;
        #1;
        check("async_pndng", 32'(pndng), 32'h0);
        check("async_d_pop", 32'(D_pop), 32'h0);
        clear_model();
        tx_wr = 1; push = 1; D_push = 16'h0301; tx_data = 16'hBEEF;
        @(posedge clk);
        #1;
        check_outputs();
        reset = 0;
        idle(); pop = 1; cycle();
        idle(); cycle();

`ifdef DEV_PORT_FIFO_STATS_EN
        for (int i = 0; i < DEPTH + 3; i++) begin tx_wr = 1; tx_data = 16'(i); cycle(); end
        check("tx_drop_3", 32'(tx_drop_cnt), 32'd3);
        do_reset();
`endif

        // Randomized traffic with mixed destinations.
        for (int n = 0; n < 600; n++) begin
            tx_wr   = ($urandom_range(99) < 55);
            pop     = ($urandom_range(99) < 40);
            push    = ($urandom_range(99) < 55);
            rx_rd   = ($urandom_range(99) < 40);
            tx_data = 16'($urandom);
            case ($urandom_range(2))
                0:       D_push = {8'h03, 8'($urandom)};
                1:       D_push = {8'hFF, 8'($urandom)};
                default: D_push = 16'($urandom);
            endcase
            cycle();
            if ($urandom_range(199) == 0) do_reset();
        end
        idle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dev_port_fifo.md
DEV_PORT_FIFO -- requirements
Module: dev_port_fifo

Interface
REQ-001 Parameter PCKG_SZ, default 16, SHALL set the packet width in bits; the destination ID is bits [PCKG_SZ-1:PCKG_SZ-8].
REQ-002 Parameter DEPTH, default 8, SHALL set the entries per FIFO (power of two, >=2).
REQ-003 Parameter DEV_ID, default 0, SHALL set this device's 8-bit bus address.
REQ-004 Parameter BROADCAST, default 8'hFF, SHALL set the broadcast destination ID.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tx_wr  input  1  host write strobe into TX FIFO.
REQ-008 tx_data  input  PCKG_SZ  host packet to transmit.
REQ-009 tx_full  output  1  TX FIFO full.
REQ-010 pndng  output  1  TX packet pending toward bus arbiter.
REQ-011 pop  input  1  bus arbiter consumes TX head.
REQ-012 D_pop  output  PCKG_SZ  TX head packet presented to bus.
REQ-013 push  input  1  bus arbiter delivers a packet.
REQ-014 D_push  input  PCKG_SZ  delivered packet.
REQ-015 rx_rd  input  1  host read strobe from RX FIFO.
REQ-016 rx_data  output  PCKG_SZ  RX head packet.
REQ-017 rx_empty  output  1  RX FIFO empty.
REQ-018 err_pulse  output  3  one-cycle flags {misroute, rx_overflow, tx_overflow}.

Function
REQ-019 TX and RX FIFOs SHALL be first-word-fall-through: head valid on D_pop/rx_data whenever non-empty.
REQ-020 pndng SHALL equal TX non-empty; tx_wr into empty FIFO SHALL raise pndng the following cycle.
REQ-021 pop SHALL retire the TX head on that edge; the next entry SHALL appear on D_pop the following cycle.
REQ-022 D_pop and rx_data SHALL read all-zero while their FIFO is empty.
REQ-023 tx_wr while full without same-cycle pop SHALL drop the packet and pulse err_pulse[0]; with same-cycle pop it SHALL be accepted.
REQ-024 pop while TX empty SHALL be ignored with no state change.
REQ-025 push SHALL be accepted only if the destination ID equals DEV_ID or BROADCAST; otherwise drop and pulse err_pulse[2].
REQ-026 Accepted push while RX full without same-cycle rx_rd SHALL drop and pulse err_pulse[1]; with same-cycle rx_rd it SHALL be accepted.
REQ-027 rx_rd while RX empty SHALL be ignored.
REQ-028 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an extra pointer MSB or occupancy counter, never ambiguous.
REQ-029 Simultaneous write and read on a non-full, non-empty FIFO SHALL leave occupancy unchanged.

Reset
REQ-030 Assertion of reset SHALL immediately clear pointers and occupancy, forcing pndng=0, tx_full=0, rx_empty=1, D_pop=0, rx_data=0, err_pulse=0.
REQ-031 Reset mid-transfer SHALL discard all stored packets; stimulus during reset SHALL be ignored.
REQ-032 Operation SHALL resume on the first rising edge after deassertion.

Configuration
REQ-033 With DEV_PORT_FIFO_STATS_EN defined, the block SHALL add outputs tx_drop_cnt, rx_drop_cnt, misroute_cnt (16 bits each, saturating, cleared by reset), incremented with the matching err_pulse bit.
REQ-034 Without DEV_PORT_FIFO_STATS_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-035 A shared package SHALL hold the packet typedef (dest ID field plus payload), the ID field width constant 8, and the err_pulse bit-index constants.
REQ-036 A sub-module sync_fifo (params WIDTH, DEPTH; FWFT; wr/rd/full/empty/data) SHALL be instantiated twice, for TX and RX.

Verification
REQ-037 Reset, tx_wr 16'h0312 -> pndng=1 next cycle, D_pop=16'h0312; pop -> pndng=0, D_pop=0 next cycle.
REQ-038 Eight tx_wr (DEPTH=8) then ninth -> tx_full=1, err_pulse[0] one cycle; ninth plus pop same cycle -> accepted, tx_full stays 1.
REQ-039 DEV_ID=3: push 16'h0355 accepted, push 16'hFF01 accepted, push 16'h0577 -> err_pulse[2], rx_empty behaviour reflects two entries.
REQ-040 Fill RX with 8 pushes, ninth -> err_pulse[1]; rx_rd sequence returns packets in order then rx_empty=1.
REQ-041 Reset asserted with 4 TX entries mid-pop -> pndng=0, D_pop=0 asynchronously; post-reset pop ignored.
REQ-042 With DEV_PORT_FIFO_STATS_EN, 3 tx overflows -> tx_drop_cnt=3; reset -> 0.
